// File: rtl/fifo_rd_packer.sv
// ============================================================================
// Module   : fifo_rd_packer
// Purpose  : Drains a synchronous FIFO and packs RATIO narrow words into one
//            wide valid/ready beat. Partial-word flush: FIFO_RD_PACKER_FLUSH_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_rd_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fifo_empty,
  output logic                        fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]       fifo_rd_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_WIDTH*RATIO-1:0] m_data,
  output logic [RATIO-1:0]            m_keep
`ifdef FIFO_RD_PACKER_FLUSH_EN
  ,
  input  logic                        flush
`endif
);

  localparam int            CW      = $clog2(RATIO + 1);
  localparam logic [CW:0]   C_RATIO = (CW + 1)'(RATIO);
  localparam logic [CW-1:0] C_LAST  = CW'(RATIO - 1);
  localparam logic [CW-1:0] C_FULL  = CW'(RATIO);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  logic [DATA_WIDTH-1:0]       acc [RATIO];
  logic [CW-1:0]               lane_cnt;
  logic                        pend;
  logic                        flush_req;
  logic                        out_free;
  logic [DATA_WIDTH*RATIO-1:0] acc_flat;
  logic [DATA_WIDTH*RATIO-1:0] bypass_flat;

  assign out_free = !m_valid || m_ready;

  // Count in-flight read as occupied so returning data always has a lane.
  assign fifo_rd_en = !rst && !fifo_empty && !flush_req &&
                      (({1'b0, lane_cnt} + {{CW{1'b0}}, pend}) < C_RATIO);

  always_comb begin
    acc_flat    = '0;
    bypass_flat = '0;
    for (int i = 0; i < RATIO; i++) begin
      acc_flat[i*DATA_WIDTH +: DATA_WIDTH]    = acc[i];
      bypass_flat[i*DATA_WIDTH +: DATA_WIDTH] = (i == RATIO - 1) ? fifo_rd_data : acc[i];
    end
  end

`ifdef FIFO_RD_PACKER_FLUSH_EN
  logic [DATA_WIDTH*RATIO-1:0] part_flat;
  logic [RATIO-1:0]            part_keep;

  always_comb begin
    part_flat = '0;
    part_keep = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (i < int'(lane_cnt)) begin
        part_flat[i*DATA_WIDTH +: DATA_WIDTH] = acc[i];
        part_keep[i]                          = 1'b1;
      end
    end
  end
`else
  assign flush_req = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RATIO; i++) acc[i] <= '0;
      lane_cnt <= '0;
      pend     <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_keep   <= '0;
`ifdef FIFO_RD_PACKER_FLUSH_EN
      flush_req <= 1'b0;
`endif
    end else begin
      pend <= fifo_rd_en;
      if (m_valid && m_ready) m_valid <= 1'b0;

      for (int i = 0; i < RATIO; i++) begin
        if (pend && (lane_cnt == CW'(i))) acc[i] <= fifo_rd_data;
      end

      if (pend) begin
        if (lane_cnt == C_LAST) begin
          if (out_free) begin
            m_data   <= bypass_flat;
            m_keep   <= '1;
            m_valid  <= 1'b1;
            lane_cnt <= '0;
          end else begin
            lane_cnt <= C_FULL;
          end
        end else begin
          lane_cnt <= lane_cnt + C_ONE;
        end
      end else if (lane_cnt == C_FULL) begin
        if (out_free) begin
          m_data   <= acc_flat;
          m_keep   <= '1;
          m_valid  <= 1'b1;
          lane_cnt <= '0;
        end
      end
`ifdef FIFO_RD_PACKER_FLUSH_EN
      else if (flush_req && out_free) begin
        if (lane_cnt != '0) begin
          m_data   <= part_flat;
          m_keep   <= part_keep;
          m_valid  <= 1'b1;
          lane_cnt <= '0;
        end
        flush_req <= 1'b0;
      end

      if (flush && !flush_req) flush_req <= 1'b1;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
// ============================================================================
// Module   : tb_fifo_rd_packer
// Purpose  : Directed and randomized checks of fifo_rd_packer against a small
//            FIFO model; flush cases build with FIFO_RD_PACKER_FLUSH_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_rd_packer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- instance 1: DATA_WIDTH=8, RATIO=4 ----------------
  logic        fifo_empty1, fifo_rd_en1, m_valid1, m_ready1;
  logic [7:0]  fifo_rd_data1;
  logic [31:0] m_data1;
  logic [3:0]  m_keep1;
  logic [7:0]  mem1 [0:255];
  int          wr1 = 0;
  int          rd1 = 0;
  logic [35:0] got1 [$];
`ifdef FIFO_RD_PACKER_FLUSH_EN
  logic        flush1 = 1'b0;
`endif

  assign fifo_empty1 = (wr1 == rd1);

  fifo_rd_packer #(.DATA_WIDTH(8), .RATIO(4)) dut1 (
    .clk(clk), .rst(rst),
    .fifo_empty(fifo_empty1), .fifo_rd_en(fifo_rd_en1), .fifo_rd_data(fifo_rd_data1),
    .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1), .m_keep(m_keep1)
`ifdef FIFO_RD_PACKER_FLUSH_EN
    , .flush(flush1)
`endif
  );

  always @(posedge clk) begin
    if (fifo_rd_en1) begin
      fifo_rd_data1 <= mem1[rd1[7:0]];
      rd1           <= rd1 + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst && m_valid1 && m_ready1) got1.push_back({m_keep1, m_data1});
  end

  // ---------------- instance 2: DATA_WIDTH=16, RATIO=3 ----------------
  localparam int N2 = 1000;
  logic        fifo_empty2, fifo_rd_en2, m_valid2, m_ready2;
  logic        gate2 = 1'b1;
  logic [15:0] fifo_rd_data2;
  logic [47:0] m_data2;
  logic [2:0]  m_keep2;
  logic [15:0] mem2 [0:N2-1];
  int          rd2 = 0;
  int          viol2 = 0;
  logic [47:0] got2 [$];
`ifdef FIFO_RD_PACKER_FLUSH_EN
  logic        flush2 = 1'b0;
`endif

  assign fifo_empty2 = (rd2 >= N2) || gate2;

  fifo_rd_packer #(.DATA_WIDTH(16), .RATIO(3)) dut2 (
    .clk(clk), .rst(rst),
    .fifo_empty(fifo_empty2), .fifo_rd_en(fifo_rd_en2), .fifo_rd_data(fifo_rd_data2),
    .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2), .m_keep(m_keep2)
`ifdef FIFO_RD_PACKER_FLUSH_EN
    , .flush(flush2)
`endif
  );

  always @(posedge clk) begin
    if (fifo_rd_en2) begin
      if (fifo_empty2) viol2 <= viol2 + 1;
      else begin
        fifo_rd_data2 <= mem2[rd2];
        rd2           <= rd2 + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && m_valid2 && m_ready2) got2.push_back(m_data2);
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push1(input logic [7:0] d);
    mem1[wr1[7:0]] = d;
    wr1 = wr1 + 1;
  endtask

  typedef struct packed {
    logic        rdy;
    logic        exp_rd;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
  } vec_t;

  vec_t        vecs [8];
  logic [35:0] w;
  logic [47:0] e2;
  int          base;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0,        4'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0,        4'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0,        4'h0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0,        4'h0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0,        4'h0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h44332211, 4'hF};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h44332211, 4'hF};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 32'h44332211, 4'hF};

    m_ready1 = 1'b0;
    m_ready2 = 1'b0;
    for (int i = 0; i < N2; i++) mem2[i] = 16'($urandom);

    // Reset state with a non-empty FIFO: no read may be issued.
    push1(8'h11); push1(8'h22); push1(8'h33); push1(8'h44);
    #2;
    chk("reset_valid", 64'(m_valid1), 64'h0);
    chk("reset_data",  64'(m_data1),  64'h0);
    chk("reset_keep",  64'(m_keep1),  64'h0);
    chk("reset_rd_en", 64'(fifo_rd_en1), 64'h0);
    step(); step();
    rst = 1'b0;

    // Basic pack: cycle-by-cycle table.
    for (int i = 0; i < 8; i++) begin
      m_ready1 = vecs[i].rdy;
      #2;
      chk($sformatf("basic_rd_en[%0d]", i), 64'(fifo_rd_en1), 64'(vecs[i].exp_rd));
      chk($sformatf("basic_valid[%0d]", i), 64'(m_valid1),    64'(vecs[i].exp_valid));
      chk($sformatf("basic_data[%0d]", i),  64'(m_data1),     64'(vecs[i].exp_data));
      chk($sformatf("basic_keep[%0d]", i),  64'(m_keep1),     64'(vecs[i].exp_keep));
      step();
    end
    chk("basic_transfers", 64'(got1.size()), 64'd1);

    // Backpressure: 12 words, downstream stalled for 30 cycles.
    got1.delete();
    m_ready1 = 1'b0;
    base = rd1;
    for (int i = 1; i <= 12; i++) push1(8'(i));
    repeat (30) step();
    chk("bp_reads_stalled", 64'(rd1 - base), 64'd8);
    chk("bp_valid_held",    64'(m_valid1),   64'h1);
    chk("bp_data_held",     64'(m_data1),    64'h04030201);
    m_ready1 = 1'b1;
    repeat (20) step();
    chk("bp_count", 64'(got1.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      w = (got1.size() > i) ? got1[i] : '0;
      chk($sformatf("bp_word[%0d]", i), 64'(w),
          64'({4'hF, 8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)}));
    end

    // Asynchronous reset with lane_cnt=3 and a read in flight.
    got1.delete();
    push1(8'h50); push1(8'h51); push1(8'h52); push1(8'h53);
    repeat (4) step();
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(m_valid1),    64'h0);
    chk("arst_data",  64'(m_data1),     64'h0);
    chk("arst_keep",  64'(m_keep1),     64'h0);
    chk("arst_rd_en", 64'(fifo_rd_en1), 64'h0);
    step();
    rst = 1'b0;
    push1(8'h61); push1(8'h62); push1(8'h63); push1(8'h64);
    repeat (10) step();
    chk("arst_count", 64'(got1.size()), 64'd1);
    w = (got1.size() > 0) ? got1[0] : '0;
    chk("arst_word", 64'(w), 64'h0F_64636261);

`ifdef FIFO_RD_PACKER_FLUSH_EN
    // Partial flush after two words, then a normal word from lane 0.
    got1.delete();
    push1(8'hAA); push1(8'hBB);
    repeat (6) step();
    flush1 = 1'b1;
    step();
    flush1 = 1'b0;
    for (int k = 0; k < 10 && got1.size() == 0; k++) step();
    chk("flush_count", 64'(got1.size()), 64'd1);
    w = (got1.size() > 0) ? got1[0] : '0;
    chk("flush_word", 64'(w), 64'h03_0000BBAA);
    push1(8'h01); push1(8'h02); push1(8'h03); push1(8'h04);
    repeat (10) step();
    chk("after_flush_count", 64'(got1.size()), 64'd2);
    w = (got1.size() > 1) ? got1[1] : '0;
    chk("after_flush_word", 64'(w), 64'h0F_04030201);

    // Empty flush: nothing emitted, reads unblocked two edges later.
    flush1 = 1'b1;
    step();
    flush1 = 1'b0;
    step();
    push1(8'h99);
    #2;
    chk("empty_flush_rd_en", 64'(fifo_rd_en1), 64'h1);
    repeat (5) step();
    chk("empty_flush_count", 64'(got1.size()), 64'd2);
`endif

    // Random empty/ready over 1000 words on the RATIO=3 instance.
    for (int c = 0; c < 20000 && got2.size() < N2 / 3; c++) begin
      gate2    = ($urandom_range(3) == 0);
      m_ready2 = ($urandom_range(3) != 0);
      step();
    end
    gate2    = 1'b0;
    m_ready2 = 1'b1;
    repeat (20) step();
    chk("rand_count", 64'(got2.size()), 64'(N2 / 3));
    chk("rand_rd_while_empty", 64'(viol2), 64'd0);
    for (int k = 0; k < N2 / 3; k++) begin
      e2 = {mem2[3*k+2], mem2[3*k+1], mem2[3*k]};
      w  = '0;
      chk($sformatf("rand_word[%0d]", k),
          64'((got2.size() > k) ? got2[k] : 48'h0), 64'(e2));
    end
    chk("rand_keep", 64'(m_keep2), 64'h7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side consumer of the synchronous FIFO.
- Drains narrow DATA_WIDTH words through the FIFO's read port, which returns data one cycle after a read. Packs RATIO consecutive words into one wide word.
- Presents the wide word downstream on a valid/ready stream.
- An optional flush emits a partially filled word with a lane-keep mask.

Parameters:
- DATA_WIDTH, 8, width of one FIFO word; must match the FIFO's data width.
- RATIO, 4, FIFO words packed per output word; legal range 2..16, need not be a power of two.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  FIFO read request (combinational).
- fifo_rd_data  input  DATA_WIDTH  FIFO registered read data; valid in the cycle after an accepted read.
- m_valid  output  1  wide word valid.
- m_ready  input  1  downstream accept.
- m_data  output  DATA_WIDTH*RATIO  packed word; lane 0 = bits [DATA_WIDTH-1:0] = oldest FIFO word.
- m_keep  output  RATIO  per-lane valid mask; bit i set means lane i holds data.
- flush  input  1  single-cycle request to emit the partial word (only present with FIFO_RD_PACKER_FLUSH_EN).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: m_valid=0, m_data=0, m_keep=0, lane_cnt=0, pend=0, flush_req=0. fifo_rd_en is forced 0 while rst=1.
- Reset mid-operation discards the partial accumulation and any in-flight read. The FIFO is reset by its own logic.
- Internal state:
  - acc: RATIO lanes.
  - lane_cnt: $clog2(RATIO+1) bits, range 0..RATIO.
  - pend: 1 bit; a read was issued last cycle.
  - out register: m_data, m_keep, m_valid.
- Out register is "free" when m_valid=0 or m_ready=1.
- fifo_rd_en = !fifo_empty && (lane_cnt + pend < RATIO) && !flush_req.
  - Never issue a read whose return data has no lane to land in.
- pend <= fifo_rd_en each cycle.
- When pend=1, fifo_rd_data is written into lane lane_cnt. Then:
  - If that fills the last lane (lane_cnt==RATIO-1) and out is free: load m_data={fifo_rd_data, acc lanes}, m_keep=all ones, m_valid=1, lane_cnt=0. This is the bypass path.
  - If it fills the last lane and out is not free: store into acc, lane_cnt=RATIO, hold.
  - Otherwise: store into acc, lane_cnt+1.
- When lane_cnt==RATIO and out is free: move acc to out, m_keep=all ones, m_valid=1, lane_cnt=0. Reads resume on the next cycle.
- Latency: m_valid rises at the clock edge 2 cycles after the RATIO-th fifo_rd_en, when the output is free.
- Output handshake:
  - m_data and m_keep are stable while m_valid=1 and m_ready=0.
  - A transfer occurs when m_valid && m_ready.
  - m_valid drops after the transfer unless a new word loads in the same cycle. Back-to-back words without a bubble are permitted.
- Unused lanes of a partial word read as 0.
- Flush (feature enabled):
  - flush=1 sets flush_req, which blocks new reads. A flush while flush_req is already set is ignored.
  - Once pend=0 and out is free:
    - If lane_cnt>0: emit acc with m_keep[i]=1 for i<lane_cnt, then lane_cnt=0.
    - If lane_cnt==0: emit nothing.
    - In both cases clear flush_req.
  - If lane_cnt reaches RATIO during the flush, emit a normal full word.
- m_ready may be asserted with m_valid=0; this has no effect.

Optional Feature:
- Macro FIFO_RD_PACKER_FLUSH_EN.
- Defined: flush port, flush_req register and partial-word emission exist as above.
- Undefined: flush port absent; words are emitted only when all RATIO lanes are filled; m_keep is constant all ones once m_valid=1 (0 after reset until the first word).

Test Plan:
- Reset, FIFO holds 0x11,0x22,0x33,0x44, m_ready=1 -> 4 consecutive fifo_rd_en; m_data=0x44332211, m_keep=4'hF, m_valid 2 cycles after the 4th read; exactly one transfer.
- 12 words 0x01..0x0C, m_ready=0 until cycle 30 -> fifo_rd_en stops once acc and out are full (8 words read); words 0x04030201, 0x08070605, 0x0C0B0A09 in order after m_ready=1; no loss or duplication.
- FIFO goes empty after 2 words (0xAA,0xBB), then flush pulse -> m_data=0x0000BBAA, m_keep=4'b0011; next 4 words pack normally from lane 0.
- Flush with lane_cnt=0 and no pending read -> no m_valid; flush_req clears within 2 cycles.
- Assert rst for 1 cycle with lane_cnt=3 and pend=1 -> all outputs 0 immediately (asynchronous); the stale returning word is not captured.
- RATIO=3, DATA_WIDTH=16, random fifo_empty and m_ready over 1000 words -> output stream equals input order; fifo_rd_en never asserted while fifo_empty=1.
